prt_dp_pm_hpd: RTL and testbench
================================

Name: prt_dp_pm_hpd

Overview:
- Hot-plug-detect (HPD) monitor in the policy-maker (PM) subsystem, directly downstream of the PM timer.
- Consumes the timer's 1 MHz BEAT output as a microsecond time base.
- Synchronises and measures the sink HPD line, then classifies events into three kinds:
  - plug,
  - unplug,
  - IRQ_HPD pulse.
- Exposes the events through a local-bus register set and raises an interrupt to the PM CPU.

Parameters:
- P_SIM, 0, 1 scales all thresholds by 1/10 for simulation.
- P_PLUG_US, 100, HPD high time (µs) required to declare plug.
- P_GLITCH_US, 250, low pulses shorter than this (µs) are ignored.
- P_UNPLUG_US, 2000, low time (µs) that declares unplug. Lows from P_GLITCH_US to P_UNPLUG_US-1 are IRQ_HPD.

Ports:
- RST_IN  in  1  asynchronous reset, active-high.
- CLK_IN  in  1  clock.
- LB_IF  prt_dp_lb_if.lb_in  -  local bus: adr[2:0], wr, rd, din[31:0], dout[31:0], vld.
- BEAT_IN  in  1  1 MHz beat from the PM timer; its rising edge is one µs tick.
- HPD_IN  in  1  raw HPD pin, asynchronous.
- HPD_OUT  out  1  qualified connection state (1 = connected).
- IRQ_OUT  out  1  interrupt, level, registered.

Behaviour:
- Reset: every flop resets asynchronously. Reset values: ctl=0, sta=0, FSM=UNPLUGGED, cnt=0, width=0, HPD_OUT=0, IRQ_OUT=0.
- Local bus:
  - adr/rd/wr/din are registered once.
  - dout and vld are combinational from the registered bus: vld = registered rd, so read data appears 1 cycle after rd.
  - Unmapped addresses read 'hdeadcafe.
- Register map:
  - 0 CTL (rw): bit0 RUN, bit1 IE.
  - 1 STA: bit0 IRQ (ro), bit1 HPD_OUT (ro), bit2 PLUG, bit3 UNPLUG, bit4 IRQ_HPD. Bits 2-4 are sticky and write-1-to-clear.
  - 2 WIDTH (ro): last classified low-pulse duration in µs, 12 bits, zero-extended.
- Sync: HPD_IN passes through a 2-FF synchroniser into hpd_s.
- Tick: tick = rising edge of BEAT_IN, 1 CLK wide.
- Counter cnt: 12 bits, saturates at 4095. It is cleared on every FSM state change and increments on tick. Measurement resolution is ±1 µs.
- FSM state UNPLUGGED (HPD_OUT=0):
  - hpd_s=0 → cnt cleared.
  - hpd_s=1 and cnt reaches P_PLUG_US → set PLUG, go to CONNECTED.
- FSM state CONNECTED (HPD_OUT=1):
  - hpd_s=0 → go to LOW_MEAS, cnt cleared.
- FSM state LOW_MEAS (HPD_OUT stays 1):
  - cnt reaches P_UNPLUG_US while low → set UNPLUG, WIDTH=cnt, go to UNPLUGGED. HPD_OUT=0 the next cycle.
  - hpd_s=1 with cnt < P_GLITCH_US → back to CONNECTED, no event, WIDTH unchanged.
  - hpd_s=1 with P_GLITCH_US ≤ cnt < P_UNPLUG_US → set IRQ_HPD, WIDTH=cnt, go to CONNECTED.
- A threshold compare uses cnt after the tick that reached it. An event flag sets in the cycle the FSM transitions.
- Sticky set vs W1C clear in the same cycle: set wins, so no event is lost.
- RUN=0:
  - FSM forced to UNPLUGGED; cnt and sticky bits cleared; HPD_OUT=0.
  - WIDTH is held.
  - Dropping RUN mid-measurement aborts the measurement with no event.
- IRQ: IRQ_OUT <= IE & (PLUG | UNPLUG | IRQ_HPD). One-cycle latency from the sticky bit; IRQ_OUT stays asserted until every sticky bit is cleared or IE=0.
- BEAT_IN stopped (timer not running): cnt freezes and the FSM holds state. This is not an error.

Decomposition:
- Shared package prt_dp_pm_pkg holds:
  - HPD register addresses and STA/CTL bit localparams;
  - the FSM enum (UNPLUGGED, CONNECTED, LOW_MEAS);
  - the lb_struct typedef, also used by the timer.
- Edge detection for BEAT_IN uses the existing prt_dp_lib_edge.
- Natural new sub-module: prt_dp_lib_sync (2-FF synchroniser, parameterised width), reusable elsewhere.
- All else stays in one module.

Test Plan:
- Plug: RUN=1, IE=1; HPD_IN high for 150 µs → PLUG set at ~100 µs, HPD_OUT=1, IRQ_OUT=1; reading STA gives 0x7.
- IRQ_HPD: connected, HPD low 600 µs → IRQ_HPD set, WIDTH 599-601, HPD_OUT stays 1; W1C 0x10 → IRQ_OUT falls the next cycle.
- Glitch: connected, HPD low 100 µs → no STA change, WIDTH unchanged, IRQ_OUT stays 0.
- Unplug: connected, HPD low 2500 µs → UNPLUG set at ~2000 µs, HPD_OUT=0; a later 50 µs high pulse produces no PLUG.
- Race: write STA=0x10 in the same cycle IRQ_HPD sets → bit4 remains 1, IRQ_OUT remains 1.
- Abort: clear RUN at 300 µs into a low pulse → STA bits 1-4 read 0, HPD_OUT=0; re-enable with HPD high → PLUG after 100 µs.

Source files
------------

// File: rtl/prt_dp_pm_pkg.sv
// Shared policy-maker definitions: HPD register map, HPD FSM states and the local-bus request struct.
// Also used by the PM timer.
package prt_dp_pm_pkg;

    localparam logic [2:0]  HPD_ADR_CTL   = 3'd0;
    localparam logic [2:0]  HPD_ADR_STA   = 3'd1;
    localparam logic [2:0]  HPD_ADR_WIDTH = 3'd2;
    localparam logic [31:0] LB_UNMAPPED   = 32'hdeadcafe;

    localparam int CTL_RUN     = 0;
    localparam int CTL_IE      = 1;
    localparam int STA_IRQ     = 0;
    localparam int STA_HPD     = 1;
    localparam int STA_PLUG    = 2;
    localparam int STA_UNPLUG  = 3;
    localparam int STA_IRQ_HPD = 4;

    typedef enum logic [1:0] {
        UNPLUGGED = 2'd0,
        CONNECTED = 2'd1,
        LOW_MEAS  = 2'd2
    } hpd_state_t;

    typedef struct packed {
        logic [2:0]  adr;
        logic        wr;
        logic        rd;
        logic [31:0] din;
    } lb_struct;

    // Simulation builds shorten every threshold tenfold.
    function automatic logic [11:0] hpd_thr(input int us, input bit sim);
        int v;
        v = sim ? us / 10 : us;
        return v[11:0];
    endfunction

endpackage

// File: rtl/prt_dp_lb_if.sv
// Local register bus: one request per cycle, read data returned with vld the cycle after rd.
// No backpressure: the slave accepts every request.
interface prt_dp_lb_if;
    logic [2:0]  adr;
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic [31:0] dout;
    logic        vld;

    modport lb_in  (input adr, wr, rd, din, output dout, vld);
    modport lb_out (output adr, wr, rd, din, input dout, vld);
endinterface

// File: rtl/prt_dp_lib_edge.sv
// Rising-edge detector for a core-clock-synchronous level; pulse is combinational, one cycle wide.
// No backpressure.
module prt_dp_lib_edge (
    input  logic CLK_IN,
    input  logic RST_IN,
    input  logic dat_i,
    output logic re_o
);
    logic dat_q;

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) dat_q <= 1'b0;
        else        dat_q <= dat_i;
    end

    assign re_o = dat_i & ~dat_q;
endmodule

// File: rtl/prt_dp_lib_sync.sv
// Two-flop synchroniser for asynchronous level inputs; 2 cycles latency.
// No backpressure.
module prt_dp_lib_sync #(
    parameter int P_WIDTH = 1
) (
    input  logic               CLK_IN,
    input  logic               RST_IN,
    input  logic [P_WIDTH-1:0] dat_i,
    output logic [P_WIDTH-1:0] dat_o
);
    logic [P_WIDTH-1:0] meta_q;
    logic [P_WIDTH-1:0] sync_q;

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= dat_i;
            sync_q <= meta_q;
        end
    end

    assign dat_o = sync_q;
endmodule

// File: rtl/prt_dp_pm_hpd.sv
// HPD monitor: classifies plug/unplug/IRQ_HPD from a us-timed HPD line; event one cycle after threshold, IRQ one more.
// No backpressure: register writes always accepted, reads return one cycle after rd.
module prt_dp_pm_hpd
    import prt_dp_pm_pkg::*;
#(
    parameter int P_SIM       = 0,
    parameter int P_PLUG_US   = 100,
    parameter int P_GLITCH_US = 250,
    parameter int P_UNPLUG_US = 2000
) (
    input  logic            RST_IN,
    input  logic            CLK_IN,
    prt_dp_lb_if.lb_in      LB_IF,
    input  logic            BEAT_IN,
    input  logic            HPD_IN,
    output logic            HPD_OUT,
    output logic            IRQ_OUT
);
    localparam logic [11:0] PLUG_TH   = hpd_thr(P_PLUG_US,   P_SIM != 0);
    localparam logic [11:0] GLITCH_TH = hpd_thr(P_GLITCH_US, P_SIM != 0);
    localparam logic [11:0] UNPLUG_TH = hpd_thr(P_UNPLUG_US, P_SIM != 0);

    lb_struct                      lb_q;
    hpd_state_t                    state_q, state_d;
    logic [11:0]                   cnt_q, cnt_d;
    logic [11:0]                   width_q, width_d;
    logic [1:0]                    ctl_q, ctl_d;
    logic [STA_IRQ_HPD:STA_PLUG]   sticky_q, sticky_d, sticky_set, sticky_clr;
    logic                          irq_q;
    logic                          hpd_s;
    logic                          tick;
    logic                          run;
    logic                          lb_unused;

    prt_dp_lib_sync #(.P_WIDTH(1)) u_hpd_sync (
        .CLK_IN (CLK_IN),
        .RST_IN (RST_IN),
        .dat_i  (HPD_IN),
        .dat_o  (hpd_s)
    );

    prt_dp_lib_edge u_beat_edge (
        .CLK_IN (CLK_IN),
        .RST_IN (RST_IN),
        .dat_i  (BEAT_IN),
        .re_o   (tick)
    );

    assign run       = ctl_q[CTL_RUN];
    assign lb_unused = ^lb_q.din[31:5];

    // Thresholds compare the registered count, i.e. the value after the tick that reached it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        width_d    = width_q;
        sticky_set = '0;
        if (tick && cnt_q != 12'hfff) cnt_d = cnt_q + 12'd1;
        case (state_q)
            UNPLUGGED: begin
                if (!hpd_s) begin
                    cnt_d = '0;
                end else if (cnt_q >= PLUG_TH) begin
                    state_d              = CONNECTED;
                    sticky_set[STA_PLUG] = 1'b1;
                end
            end
            CONNECTED: begin
                if (!hpd_s) state_d = LOW_MEAS;
            end
            LOW_MEAS: begin
                if (!hpd_s) begin
                    if (cnt_q >= UNPLUG_TH) begin
                        state_d                = UNPLUGGED;
                        width_d                = cnt_q;
                        sticky_set[STA_UNPLUG] = 1'b1;
                    end
                end else begin
                    state_d = CONNECTED;
                    if (cnt_q >= GLITCH_TH) begin
                        width_d                 = cnt_q;
                        sticky_set[STA_IRQ_HPD] = 1'b1;
                    end
                end
            end
            default: state_d = UNPLUGGED;
        endcase
        if (state_d != state_q) cnt_d = '0;
        // Dropping RUN abandons any measurement silently; WIDTH keeps the last result.
        if (!run) begin
            state_d    = UNPLUGGED;
            cnt_d      = '0;
            width_d    = width_q;
            sticky_set = '0;
        end
    end

    always_comb begin
        ctl_d      = ctl_q;
        sticky_clr = '0;
        if (lb_q.wr && lb_q.adr == HPD_ADR_CTL) ctl_d = lb_q.din[1:0];
        if (lb_q.wr && lb_q.adr == HPD_ADR_STA) sticky_clr = lb_q.din[STA_IRQ_HPD:STA_PLUG];
        // A new event beats a simultaneous clear so nothing is lost.
        sticky_d = run ? ((sticky_q & ~sticky_clr) | sticky_set) : '0;
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            lb_q     <= '0;
            state_q  <= UNPLUGGED;
            cnt_q    <= '0;
            width_q  <= '0;
            ctl_q    <= '0;
            sticky_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            lb_q     <= '{adr: LB_IF.adr, wr: LB_IF.wr, rd: LB_IF.rd, din: LB_IF.din};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            ctl_q    <= ctl_d;
            sticky_q <= sticky_d;
            irq_q    <= ctl_q[CTL_IE] & (|sticky_q);
        end
    end

    assign HPD_OUT = (state_q != UNPLUGGED);
    assign IRQ_OUT = irq_q;

    always_comb begin
        LB_IF.dout = LB_UNMAPPED;
        case (lb_q.adr)
            HPD_ADR_CTL:   LB_IF.dout = {30'd0, ctl_q};
            HPD_ADR_STA:   LB_IF.dout = {27'd0, sticky_q, HPD_OUT, irq_q};
            HPD_ADR_WIDTH: LB_IF.dout = {20'd0, width_q};
            default:       ;
        endcase
    end

    assign LB_IF.vld = lb_q.rd;
endmodule

// File: tb/tb_prt_dp_pm_hpd.sv
// Directed bench for prt_dp_pm_hpd: a us-level behavioural model checked every cycle plus literal pins.
module tb_prt_dp_pm_hpd;
    localparam int PLUG_US   = 100;
    localparam int GLITCH_US = 250;
    localparam int UNPLUG_US = 2000;
    localparam int CYC_PER_US = 4;

    logic CLK_IN, RST_IN, BEAT_IN, HPD_IN, HPD_OUT, IRQ_OUT;
    bit   beat_en;
    int   n_cmp, n_bad;

    prt_dp_lb_if lb ();

    prt_dp_pm_hpd #(
        .P_SIM(0), .P_PLUG_US(PLUG_US), .P_GLITCH_US(GLITCH_US), .P_UNPLUG_US(UNPLUG_US)
    ) dut (
        .RST_IN  (RST_IN),
        .CLK_IN  (CLK_IN),
        .LB_IF   (lb),
        .BEAT_IN (BEAT_IN),
        .HPD_IN  (HPD_IN),
        .HPD_OUT (HPD_OUT),
        .IRQ_OUT (IRQ_OUT)
    );

    initial begin
        CLK_IN = 1'b0;
        forever #5 CLK_IN = ~CLK_IN;
    end

    // 1 us = 4 clocks; the beat holds its level while stopped.
    initial begin
        int ph;
        ph = 0;
        BEAT_IN = 1'b0;
        forever begin
            @(negedge CLK_IN);
            if (beat_en) begin
                ph = (ph + 1) % CYC_PER_US;
                BEAT_IN = (ph < 2);
            end
        end
    end

    // ---------------- behavioural model ----------------
    bit        m_s1, m_s2, m_bq, m_tick;
    bit        m_conn, m_low;
    int        m_us, m_width;
    bit [2:0]  m_sticky, m_ev, m_clr;
    bit [1:0]  m_ctl;
    bit        m_irq;
    bit        m_wr_q, m_rd_q;
    bit [2:0]  m_adr_q;
    bit [31:0] m_din_q;

    always @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            m_s1 = 0; m_s2 = 0; m_bq = 0; m_conn = 0; m_low = 0; m_us = 0; m_width = 0;
            m_sticky = 0; m_ctl = 0; m_irq = 0; m_wr_q = 0; m_rd_q = 0; m_adr_q = 0; m_din_q = 0;
        end else begin
            m_tick = BEAT_IN && !m_bq;
            m_ev   = 3'b000;
            if (!m_ctl[0]) begin
                m_conn = 0; m_low = 0; m_us = 0;
            end else if (!m_conn) begin
                // plug: line high continuously for PLUG_US microseconds
                if (!m_s2)                 m_us = 0;
                else if (m_us >= PLUG_US) begin m_conn = 1; m_us = 0; m_ev[0] = 1; end
                else                       m_us = m_us + int'(m_tick);
            end else if (!m_s2) begin
                // low pulse timing starts the cycle after the fall is seen
                if (!m_low)                  begin m_low = 1; m_us = 0; end
                else if (m_us >= UNPLUG_US)  begin m_width = m_us; m_ev[1] = 1; m_conn = 0; m_low = 0; m_us = 0; end
                else                         m_us = m_us + int'(m_tick);
            end else if (m_low) begin
                if (m_us >= GLITCH_US) begin m_width = m_us; m_ev[2] = 1; end
                m_low = 0; m_us = 0;
            end
            m_clr    = (m_wr_q && m_adr_q == 3'd1) ? m_din_q[4:2] : 3'b000;
            m_irq    = m_ctl[1] && (m_sticky != 0);
            m_sticky = m_ctl[0] ? ((m_sticky & ~m_clr) | m_ev) : 3'b000;
            if (m_wr_q && m_adr_q == 3'd0) m_ctl = m_din_q[1:0];
            m_s2 = m_s1; m_s1 = HPD_IN; m_bq = BEAT_IN;
            m_wr_q = lb.wr; m_rd_q = lb.rd; m_adr_q = lb.adr; m_din_q = lb.din;
        end
    end

    function automatic logic [31:0] m_rdata(input bit [2:0] a);
        case (a)
            3'd0:    return {30'd0, m_ctl};
            3'd1:    return {27'd0, m_sticky, m_conn, m_irq};
            3'd2:    return 32'(m_width);
            default: return 32'hdeadcafe;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d at %0t", nm, act, lo, hi, $time);
        end
    endtask

    always @(negedge CLK_IN) begin
        if (!RST_IN) begin
            chk("hpd_out_model", HPD_OUT, m_conn);
            chk("irq_out_model", IRQ_OUT, m_irq);
            chk("vld_model", lb.vld, m_rd_q);
            if (m_rd_q) chk("dout_model", lb.dout, m_rdata(m_adr_q));
        end
    end

    // ---------------- bus and timing tasks ----------------
    task automatic wait_us(input int n);
        repeat (n * CYC_PER_US) @(negedge CLK_IN);
    endtask

    task automatic lb_wr(input logic [2:0] a, input logic [31:0] d);
        lb.adr = a; lb.din = d; lb.wr = 1'b1;
        @(negedge CLK_IN);
        lb.wr = 1'b0;
        @(negedge CLK_IN);
    endtask

    task automatic lb_rd(input logic [2:0] a, output logic [31:0] d);
        lb.adr = a; lb.rd = 1'b1;
        @(negedge CLK_IN);
        lb.rd = 1'b0;
        d = lb.dout;
        chk("rd_vld", lb.vld, 1'b1);
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        lb_rd(a, d);
        chk(nm, d, exp);
    endtask

    task automatic rd_rng(input string nm, input logic [2:0] a, input int lo, input int hi);
        logic [31:0] d;
        lb_rd(a, d);
        chk_rng(nm, int'(d), lo, hi);
    endtask

    // Elapsed us until HPD_OUT reaches val; a timeout returns max_us.
    task automatic wait_hpd(input logic val, input int max_us, output int us);
        int cyc;
        cyc = 0;
        while (HPD_OUT !== val && cyc < max_us * CYC_PER_US) begin
            @(negedge CLK_IN);
            cyc++;
        end
        us = cyc / CYC_PER_US;
    endtask

    // Clear every pending sticky bit and check IRQ_OUT drops exactly one cycle later.
    task automatic clr_irq(input string nm, input logic [31:0] mask);
        lb_wr(3'd1, mask);
        chk({nm, "_irq_lag"}, IRQ_OUT, 1'b1);
        @(negedge CLK_IN);
        chk({nm, "_irq_fall"}, IRQ_OUT, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int us;
        n_cmp = 0; n_bad = 0;
        RST_IN = 1'b1; HPD_IN = 1'b0; beat_en = 1'b1;
        lb.adr = '0; lb.wr = 1'b0; lb.rd = 1'b0; lb.din = '0;
        repeat (3) @(negedge CLK_IN);
        chk("rst_hpd_out", HPD_OUT, 1'b0);
        chk("rst_irq_out", IRQ_OUT, 1'b0);
        chk("rst_vld", lb.vld, 1'b0);
        RST_IN = 1'b0;
        @(negedge CLK_IN);
        rd_chk("rst_ctl", 3'd0, 32'h0);
        rd_chk("rst_sta", 3'd1, 32'h0);
        rd_chk("rst_width", 3'd2, 32'h0);
        rd_chk("unmapped5", 3'd5, 32'hdeadcafe);

        // plug
        lb_wr(3'd0, 32'h3);
        rd_chk("ctl_rw", 3'd0, 32'h3);
        wait_us(10);
        HPD_IN = 1'b1;
        wait_hpd(1'b1, 150, us);
        chk_rng("plug_time_us", us, 99, 102);
        wait_us(50);
        rd_chk("plug_sta", 3'd1, 32'h7);
        chk("plug_irq", IRQ_OUT, 1'b1);
        clr_irq("plug_clr", 32'h4);
        rd_chk("plug_sta_clr", 3'd1, 32'h2);

        // IRQ_HPD, 600 us low
        HPD_IN = 1'b0; wait_us(600); HPD_IN = 1'b1; wait_us(20);
        rd_chk("irqhpd_sta", 3'd1, 32'h13);
        rd_rng("irqhpd_width", 3'd2, 599, 601);
        chk("irqhpd_hpd_out", HPD_OUT, 1'b1);
        clr_irq("irqhpd_clr", 32'h10);

        // glitch, 100 us low
        HPD_IN = 1'b0; wait_us(100); HPD_IN = 1'b1; wait_us(20);
        rd_chk("glitch_sta", 3'd1, 32'h2);
        rd_rng("glitch_width_held", 3'd2, 599, 601);
        chk("glitch_irq", IRQ_OUT, 1'b0);

        // race: STA W1C lands in the same cycle IRQ_HPD sets
        HPD_IN = 1'b0; wait_us(400); HPD_IN = 1'b1;
        @(negedge CLK_IN);
        lb_wr(3'd1, 32'h10);
        rd_chk("race_sta", 3'd1, 32'h13);
        chk("race_irq", IRQ_OUT, 1'b1);
        clr_irq("race_clr", 32'h10);

        // beat stalls mid-pulse: time freezes, state holds
        HPD_IN = 1'b0; wait_us(150);
        beat_en = 1'b0;
        repeat (2000) @(negedge CLK_IN);
        chk("stall_hpd_out", HPD_OUT, 1'b1);
        beat_en = 1'b1;
        wait_us(150); HPD_IN = 1'b1; wait_us(20);
        rd_rng("stall_width", 3'd2, 298, 302);
        rd_chk("stall_sta", 3'd1, 32'h13);
        clr_irq("stall_clr", 32'h10);

        // unplug, 2500 us low
        HPD_IN = 1'b0;
        wait_hpd(1'b0, 2100, us);
        chk_rng("unplug_time_us", us, 1999, 2002);
        wait_us(500);
        rd_chk("unplug_sta", 3'd1, 32'h9);
        rd_chk("unplug_width", 3'd2, 32'd2000);
        HPD_IN = 1'b1; wait_us(50); HPD_IN = 1'b0; wait_us(20);
        rd_chk("short_high_sta", 3'd1, 32'h9);
        chk("short_high_hpd_out", HPD_OUT, 1'b0);
        clr_irq("unplug_clr", 32'h8);

        // abort: RUN dropped 300 us into a low pulse
        HPD_IN = 1'b1;
        wait_hpd(1'b1, 150, us);
        chk_rng("replug_time_us", us, 99, 102);
        wait_us(50);
        clr_irq("replug_clr", 32'h4);
        HPD_IN = 1'b0; wait_us(300);
        lb_wr(3'd0, 32'h2);
        rd_chk("abort_sta", 3'd1, 32'h0);
        chk("abort_hpd_out", HPD_OUT, 1'b0);
        rd_chk("abort_width_held", 3'd2, 32'd2000);
        HPD_IN = 1'b1; wait_us(10);
        lb_wr(3'd0, 32'h3);
        wait_hpd(1'b1, 150, us);
        chk_rng("rerun_plug_us", us, 98, 102);
        wait_us(50);
        rd_chk("rerun_sta", 3'd1, 32'h7);
        rd_chk("unmapped3", 3'd3, 32'hdeadcafe);
        rd_chk("unmapped7", 3'd7, 32'hdeadcafe);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
